// File: rtl/gray_share_arbiter_pkg.sv
// Shared definitions for the Gray translator arbiter: response FSM states,
// width helper and the binary-to-Gray conversion.
package gray_share_arbiter_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_t;

    // Width needed to index n items, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

    // Binary to Gray; the zero-extended MSB keeps out[msb] = in[msb] for any width.
    function automatic logic [31:0] gray32(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from i_last+1 upward with wrap and grants
// the first active request. The index is valid even when i_en is low.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
)(
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    input  logic          i_en,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    logic          w_found;
    logic [IW-1:0] w_cand;

    // Rotating priority search, first valid requester after the last grant wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            w_cand = IW'((32'(i_last) + off) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                o_idx   = w_cand;
            end
        end
        if (w_found && i_en) o_grant[o_idx] = 1'b1;
    end

endmodule

// File: rtl/gray_share_arbiter.sv
// One Gray translator shared between NUM_REQ requesters. A round-robin
// arbiter picks a request whenever the response register can take it; the
// converted vector and requester ID are held until the consumer accepts.
module gray_share_arbiter
    import gray_share_arbiter_pkg::*;
#(
    parameter  int unsigned SIZE    = 4,
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = clog2_min1(NUM_REQ)
)(
    input  logic                    i_CLK,
    input  logic                    i_RST_N,
    input  logic [NUM_REQ-1:0]      i_REQ_VALID,
    output logic [NUM_REQ-1:0]      o_REQ_READY,
    input  logic [NUM_REQ*SIZE-1:0] i_REQ_DATA,
    output logic                    o_RSP_VALID,
    input  logic                    i_RSP_READY,
    output logic [SIZE-1:0]         o_RSP_GRAY,
    output logic [IDX_W-1:0]        o_RSP_ID
);

    rsp_state_t         r_state;
    rsp_state_t         w_state_nxt;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_id;
    logic [SIZE-1:0]    r_gray;
    logic               w_free;
    logic               w_en;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic [SIZE-1:0]    w_sel;

    // Slot frees up when empty or when the held result drains this cycle;
    // reset also gates the combinational ready.
    assign w_free = (r_state == EMPTY) || i_RSP_READY;
    assign w_en   = w_free & i_RST_N;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_arb (
        .i_req   (i_REQ_VALID),
        .i_last  (r_last),
        .i_en    (w_en),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign o_REQ_READY = w_grant;
    assign w_xfer      = |(w_grant & i_REQ_VALID);
    assign w_sel       = i_REQ_DATA[32'(w_idx)*SIZE +: SIZE];

    assign o_RSP_VALID = (r_state == FULL);
    assign o_RSP_GRAY  = r_gray;
    assign o_RSP_ID    = r_id;

    // Response FSM state register.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) r_state <= EMPTY;
        else          r_state <= w_state_nxt;
    end

    // Next state: a transfer fills the slot, a drain without refill empties it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer)                                 w_state_nxt = FULL;
        else if ((r_state == FULL) && i_RSP_READY)  w_state_nxt = EMPTY;
    end

    // Result register and arbitration pointer, updated only on a transfer.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_last <= IDX_W'(NUM_REQ - 1);
            r_id   <= '0;
            r_gray <= '0;
        end else if (w_xfer) begin
            r_last <= w_idx;
            r_id   <= w_idx;
            r_gray <= SIZE'(gray32(32'(w_sel)));
        end
    end

endmodule

// File: tb/tb_gray_share_arbiter.sv
// Directed bench for gray_share_arbiter with an abstract reference model
// compared every cycle plus literal expectations per scenario.
module tb_gray_share_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic          rsp_ready = 1'b0;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic [W-1:0]  rsp_gray;
    logic [1:0]    rsp_id;

    int checks = 0;
    int errors = 0;

    int grants[$];
    int rsp_log[$];

    gray_share_arbiter #(
        .SIZE    (W),
        .NUM_REQ (N)
    ) dut (
        .i_CLK       (clk),
        .i_RST_N     (rst_n),
        .i_REQ_VALID (req_valid),
        .o_REQ_READY (req_ready),
        .i_REQ_DATA  (req_data),
        .o_RSP_VALID (rsp_valid),
        .i_RSP_READY (rsp_ready),
        .o_RSP_GRAY  (rsp_gray),
        .o_RSP_ID    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_full = 1'b0;
    logic [W-1:0] m_gray = '0;
    int         m_id   = 0;
    int         m_last = N - 1;
    int         m_c;
    logic [N-1:0] m_r;

    function automatic logic [W-1:0] f_gray(input logic [W-1:0] b);
        logic [W-1:0] g;
        for (int i = 0; i < W; i++)
            g[i] = (i == W - 1) ? b[i] : (b[i+1] ^ b[i]);
        return g;
    endfunction

    function automatic int m_cand();
        for (int off = 1; off <= N; off++) begin
            int k;
            k = (m_last + off) % N;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int c;
        logic [N-1:0] r;
        c = m_cand();
        r = '0;
        if (rst_n && c >= 0 && (!m_full || rsp_ready)) r[c] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full = 1'b0; m_gray = '0; m_id = 0; m_last = N - 1;
        end else begin
            m_r = m_ready();
            m_c = m_cand();
            if (m_r != '0) begin
                m_full = 1'b1;
                m_gray = f_gray(req_data[m_c*W +: W]);
                m_id   = m_c;
                m_last = m_c;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare, protocol check, logs ----------------
    bit           pend [N];
    logic [W-1:0] held [N];

    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready), 32'(m_ready()));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            chk("rsp_gray", 32'(rsp_gray), 32'(m_gray));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
        end else if (!rst_n) begin
            chk("rsp_gray_rst", 32'(rsp_gray), 32'h0);
            chk("rsp_id_rst", 32'(rsp_id), 32'h0);
        end
        for (int k = 0; k < N; k++) begin
            if (rst_n && pend[k]) begin
                checks++;
                if (!req_valid[k] || req_data[k*W +: W] != held[k]) begin
                    errors++;
                    $display("FAIL protocol: requester %0d dropped valid or changed data before transfer at %0t", k, $time);
                end
            end
            pend[k] = rst_n && req_valid[k] && !req_ready[k];
            held[k] = req_data[k*W +: W];
            if (rst_n && req_valid[k] && req_ready[k]) grants.push_back(k);
        end
        if (rst_n && rsp_valid && rsp_ready) rsp_log.push_back(int'(rsp_id));
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        step(2);
        rst_n = 1'b1;
        grants.delete();
        rsp_log.delete();
    endtask

    logic [W-1:0] prev_g;

    initial begin
        #1 rst_n = 1'b0;
        step(2);
        chk("reset_valid", 32'(rsp_valid), 32'h0);
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_gray", 32'(rsp_gray), 32'h0);
        chk("reset_id", 32'(rsp_id), 32'h0);
        rst_n = 1'b1;
        step(1);

        // single request from requester 2
        req_valid = 4'b0100;
        req_data[11:8] = 4'b1011;
        rsp_ready = 1'b1;
        #1 chk("t1_ready", 32'(req_ready), 32'h4);
        step(1);
        req_valid = '0;
        chk("t1_valid", 32'(rsp_valid), 32'h1);
        chk("t1_gray", 32'(rsp_gray), 32'he);
        chk("t1_id", 32'(rsp_id), 32'h2);
        step(1);

        // all requesters valid, full throughput
        do_reset();
        req_data  = 16'h9C35;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        step(6);
        chk("t2_ngrants", 32'(grants.size()), 32'd6);
        chk("t2_g0", 32'(grants[0]), 32'd0);
        chk("t2_g1", 32'(grants[1]), 32'd1);
        chk("t2_g2", 32'(grants[2]), 32'd2);
        chk("t2_g3", 32'(grants[3]), 32'd3);
        chk("t2_g4", 32'(grants[4]), 32'd0);
        chk("t2_g5", 32'(grants[5]), 32'd1);
        chk("t2_nrsp", 32'(rsp_log.size()), 32'd5);
        chk("t2_r0", 32'(rsp_log[0]), 32'd0);
        chk("t2_r3", 32'(rsp_log[3]), 32'd3);
        chk("t2_r4", 32'(rsp_log[4]), 32'd0);
        chk("t2_id_last", 32'(rsp_id), 32'd1);

        // backpressure with requesters 1 and 3 waiting
        do_reset();
        req_data  = 16'hA706;
        req_valid = 4'b0001;
        step(1);
        req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_ready_blocked", 32'(req_ready), 32'h0);
            chk("t3_gray_frozen", 32'(rsp_gray), 32'h5);
            chk("t3_id_frozen", 32'(rsp_id), 32'h0);
            step(1);
        end
        rsp_ready = 1'b1;
        #1 chk("t3_ready_drain", 32'(req_ready), 32'h2);
        step(1);
        chk("t3_grant", 32'(grants[$]), 32'd1);
        chk("t3_id", 32'(rsp_id), 32'd1);
        req_valid = 4'b1000;
        step(1);
        chk("t3_grant3", 32'(grants[$]), 32'd3);
        req_valid = '0;
        step(1);

        // exhaustive sweep through requester 1
        for (int v = 0; v <= 16; v++) begin
            logic [W-1:0] bv;
            bv = W'(v % 16);
            req_valid = 4'b0010;
            req_data[7:4] = bv;
            step(1);
            chk("t4_gray", 32'(rsp_gray), 32'(bv ^ (bv >> 1)));
            chk("t4_id", 32'(rsp_id), 32'd1);
            if (v > 0) chk("t4_onebit", 32'($countones(rsp_gray ^ prev_g)), 32'd1);
            if (v == 15) chk("t4_g15", 32'(rsp_gray), 32'h8);
            if (v == 16) chk("t4_g0", 32'(rsp_gray), 32'h0);
            prev_g = rsp_gray;
        end
        req_valid = '0;
        step(1);

        // fairness with holes: only 0 and 3, starting from LAST=0
        req_valid = 4'b0001;
        step(1);
        grants.delete();
        req_valid = 4'b1001;
        step(3);
        chk("t5_n", 32'(grants.size()), 32'd3);
        chk("t5_g0", 32'(grants[0]), 32'd3);
        chk("t5_g1", 32'(grants[1]), 32'd0);
        chk("t5_g2", 32'(grants[2]), 32'd3);
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        step(1);

        // reset asserted while FULL and stalled
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        step(2);
        chk("t6_full", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(rsp_valid), 32'h0);
        chk("t6_async_gray", 32'(rsp_gray), 32'h0);
        chk("t6_async_ready", 32'(req_ready), 32'h0);
        step(1);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1 chk("t6_ready_first", 32'(req_ready), 32'h1);
        step(1);
        chk("t6_id_first", 32'(rsp_id), 32'd0);
        do_reset();
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_share_arbiter.md
# gray_share_arbiter

- Shares one Gray translator between NUM_REQ requesters.
- Each requester presents a binary vector with a valid/ready handshake.
- A round-robin arbiter grants one request per cycle and converts the granted vector to Gray code in a registered output stage.
- The result is delivered with the source requester ID over a valid/ready response port; it serves any subsystem that needs Gray-coded values from several sources without duplicating translators.

## Interface
- SIZE, 4: vector width in bits; legal range 2..32.
- NUM_REQ, 4: number of requesters; legal range 2..8.
- IDX_W, derived as clog2(NUM_REQ), minimum 1: requester ID width; not overridden.

- i_CLK  input  1  sole clock, rising edge.
- i_RST_N  input  1  asynchronous active-low reset.
- i_REQ_VALID  input  NUM_REQ  per-requester request valid.
- o_REQ_READY  output  NUM_REQ  per-requester accept; at most one bit set.
- i_REQ_DATA  input  NUM_REQ*SIZE  binary vectors; requester k occupies [k*SIZE +: SIZE].
- o_RSP_VALID  output  1  response register holds a result.
- i_RSP_READY  input  1  consumer accepts the response.
- o_RSP_GRAY  output  SIZE  Gray code of the accepted vector.
- o_RSP_ID  output  IDX_W  index of the requester that supplied the vector.

## Operation
- Gray rule: out[SIZE-1] = in[SIZE-1]; out[i] = in[i+1] ^ in[i] for i < SIZE-1.
- Two-state FSM on the response register:
  - EMPTY: o_RSP_VALID=0.
  - FULL: o_RSP_VALID=1.
- Slot is free when the FSM is in EMPTY, or when it is in FULL and i_RSP_READY=1 this cycle (drain and refill in the same cycle).
- Arbitration uses pointer LAST, the index of the most recent grant.
  - Search order is LAST+1, LAST+2, ... with wrap modulo NUM_REQ.
  - The first requester with i_REQ_VALID=1 is the candidate.
- o_REQ_READY[k]=1 only when k is the candidate and the slot is free.
- A transfer occurs when i_REQ_VALID[k] & o_REQ_READY[k] are both 1. On a transfer:
  - The response register loads gray(i_REQ_DATA[k]) and ID k.
  - The FSM goes to or stays in FULL.
  - LAST is set to k.
- With no transfer, a drain (FULL & i_RSP_READY) sends the FSM to EMPTY.
- LAST changes only on a transfer. A requester that is skipped because it is not valid does not lose its turn.
- Requesters must hold valid and data stable until accepted. A bench assertion flags a drop of valid, or a data change, before the transfer.

## Timing
- Reset, asynchronous: FSM=EMPTY, o_RSP_VALID=0, o_RSP_GRAY=0, o_RSP_ID=0, LAST=NUM_REQ-1 (requester 0 has first priority).
- o_REQ_READY is combinational and is forced to all-zero while i_RST_N=0.
- Latency: a transfer at edge N makes the result visible after edge N with o_RSP_VALID=1. This is 1 cycle.
- Throughput: with i_RSP_READY held at 1, one transfer per cycle.
- Backpressure: while FULL and i_RSP_READY=0, o_RSP_GRAY and o_RSP_ID are stable and o_REQ_READY is all-zero.
- Combinational paths: i_REQ_VALID to o_REQ_READY, and i_RSP_READY to o_REQ_READY. There is no path from any input to o_RSP_*.
- Reset asserted mid-operation: any pending response is discarded and the FSM and LAST return to reset values. No partial output persists after deassertion.

## Structure
- Shared package/header holds:
  - the Gray conversion function;
  - the clog2 helper;
  - FSM state encodings EMPTY=1'b0 and FULL=1'b1.
- Natural sub-module: rr_arbiter.
  - Inputs: request vector, LAST, enable.
  - Output: one-hot grant plus encoded index.
  - Reusable by other shared-resource blocks.
- Gray conversion is done inline with the package function. It is not instantiated per requester.

## Test plan
- Reset then single request: requester 2 sends 4'b1011 with i_RSP_READY=1 → next cycle o_RSP_VALID=1, o_RSP_GRAY=4'b1110, o_RSP_ID=2.
- All four requesters valid continuously, i_RSP_READY=1 → grants 0,1,2,3,0,1 on consecutive cycles, with one response per cycle in the same order.
- Backpressure: response FULL with i_RSP_READY=0 for 3 cycles while requesters 1 and 3 are valid → o_REQ_READY=0 and outputs frozen for the 3 cycles. On the cycle i_RSP_READY=1, requester 1 is granted in the same cycle as the drain.
- Exhaustive data: requester 1 sweeps 0..15 → each output matches the Gray rule and consecutive outputs differ in exactly one bit, including 4'b1111→4'b1000 followed by 4'b0000.
- Fairness with holes: only requesters 0 and 3 valid, LAST=0 → grant 3, then 0, then 3; requesters 1 and 2 are never granted.
- Reset mid-operation: assert i_RST_N=0 while FULL with i_RSP_READY=0 → o_RSP_VALID=0 immediately (asynchronously). After release, requester 0 is granted first.
